shift_normalizer: RTL

SHIFT_NORMALIZER -- requirements
Module: shift_normalizer

---
 rtl/shift_normalizer.sv | 77 +++++++
 1 files changed

// File: rtl/shift_normalizer.sv
// Iterative one-bit-per-cycle normalizer: left (CLZ) or right (CTZ) with shift count.
// Latency 1 cycle for a zero operand, else 2+count; result is held in DONE until out_ready.
module shift_normalizer (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in,
  input  logic        mode,
  input  logic        cancel,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out,
  output logic [5:0]  count,
  output logic        zero
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t state;
  logic   dir;
  logic   test_bit;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // The working register doubles as the registered out port.
  assign test_bit = dir ? out[0] : out[31];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      out   <= 32'd0;
      count <= 6'd0;
      zero  <= 1'b0;
      dir   <= 1'b0;
    end else if (cancel) begin
      state <= IDLE;
      out   <= 32'd0;
      count <= 6'd0;
      zero  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            dir <= mode;
            if (in == 32'd0) begin
              out   <= 32'd0;
              count <= 6'd32;
              zero  <= 1'b1;
              state <= DONE;
            end else begin
              out   <= in;
              count <= 6'd0;
              zero  <= 1'b0;
              state <= SHIFT;
            end
          end
        end
        SHIFT: begin
          // A nonzero operand reaches its test bit after at most 31 shifts.
          if (test_bit) begin
            state <= DONE;
          end else begin
            out   <= dir ? (out >> 1) : (out << 1);
            count <= count + 6'd1;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
